// File: rtl/controle_unit.sv
// Registered RV32I main control decoder: opcode -> datapath steering signals,
// one cycle of latency, synchronous active-high reset clears every output.
module controle_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    output logic       ALUSrc,
    output logic       PCSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       Branch,
    output logic       Jump,
    output logic [1:0] ALUOp,
    output logic       IllegalOp
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic       alu_src_d, pc_src_d, mem_read_d, mem_write_d;
    logic       reg_write_d, mem_to_reg_d, branch_d, jump_d, illegal_d;
    logic [1:0] alu_op_d;

    always_comb begin
        alu_src_d    = 1'b0;
        pc_src_d     = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        alu_op_d     = 2'b00;
        illegal_d    = 1'b0;
        case (opcode)
            OP_R: begin
                reg_write_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            OP_I: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
                alu_op_d    = 2'b11;
            end
            OP_LOAD: begin
                alu_src_d    = 1'b1;
                mem_read_d   = 1'b1;
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            OP_STORE: begin
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            OP_BR: begin
                branch_d = 1'b1;
                alu_op_d = 2'b01;
            end
            OP_JAL: begin
                reg_write_d = 1'b1;
                pc_src_d    = 1'b1;
                jump_d      = 1'b1;
            end
            OP_JALR: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
                pc_src_d    = 1'b1;
                jump_d      = 1'b1;
            end
            // Unsupported opcodes leave every control low so nothing is written.
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALUSrc    <= 1'b0;
            PCSrc     <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            RegWrite  <= 1'b0;
            MemtoReg  <= 1'b0;
            Branch    <= 1'b0;
            Jump      <= 1'b0;
            ALUOp     <= 2'b00;
            IllegalOp <= 1'b0;
        end else begin
            ALUSrc    <= alu_src_d;
            PCSrc     <= pc_src_d;
            MemRead   <= mem_read_d;
            MemWrite  <= mem_write_d;
            RegWrite  <= reg_write_d;
            MemtoReg  <= mem_to_reg_d;
            Branch    <= branch_d;
            Jump      <= jump_d;
            ALUOp     <= alu_op_d;
            IllegalOp <= illegal_d;
        end
    end
endmodule

// File: tb/tb_controle_unit.sv
// Directed bench for controle_unit: hand-computed control words checked one
// cycle after each opcode is applied.
module tb_controle_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       ALUSrc, PCSrc, MemRead, MemWrite, RegWrite, MemtoReg, Branch, Jump, IllegalOp;
    logic [1:0] ALUOp;

    int checks = 0;
    int errors = 0;

    // Packed order: ALUSrc,PCSrc,MemRead,MemWrite,RegWrite,MemtoReg,Branch,Jump,ALUOp[1:0],IllegalOp
    localparam logic [10:0] W_ZERO = 11'b0000_0000_000;
    localparam logic [10:0] W_R    = 11'b0000_1000_100;
    localparam logic [10:0] W_I    = 11'b1000_1000_110;
    localparam logic [10:0] W_LD   = 11'b1010_1100_000;
    localparam logic [10:0] W_ST   = 11'b1001_0000_000;
    localparam logic [10:0] W_BR   = 11'b0000_0010_010;
    localparam logic [10:0] W_JAL  = 11'b0100_1001_000;
    localparam logic [10:0] W_JALR = 11'b1100_1001_000;
    localparam logic [10:0] W_ILL  = 11'b0000_0000_001;

    controle_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .ALUSrc(ALUSrc), .PCSrc(PCSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Branch(Branch), .Jump(Jump),
        .ALUOp(ALUOp), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] word();
        return {ALUSrc, PCSrc, MemRead, MemWrite, RegWrite, MemtoReg, Branch, Jump, ALUOp, IllegalOp};
    endfunction

    // Apply inputs away from the edge, then sample 1 time unit after the edge.
    task automatic step(input logic [6:0] op, input logic r);
        @(negedge clk);
        opcode = op;
        rst    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = word();
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        checks++;
        assert ((MemRead & MemWrite) === 1'b0)
        else begin
            errors++;
            $error("FAIL %s_mem_excl: observed MemRead=%b MemWrite=%b expected not both 1", tag, MemRead, MemWrite);
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 7'b0110011;
        step(7'b0110011, 1'b1); check("reset_edge1", W_ZERO);
        step(7'b0110011, 1'b1); check("reset_edge2", W_ZERO);
        step(7'b0110011, 1'b0); check("post_reset_r", W_R);

        step(7'b0000011, 1'b0); check("load", W_LD);
        step(7'b0100011, 1'b0); check("store", W_ST);
        step(7'b1100011, 1'b0); check("branch", W_BR);
        step(7'b1101111, 1'b0); check("jal", W_JAL);
        step(7'b1100111, 1'b0); check("jalr", W_JALR);
        step(7'b0010011, 1'b0); check("itype", W_I);

        step(7'b0000000, 1'b0); check("illegal_0000000", W_ILL);
        step(7'b1111111, 1'b0); check("illegal_1111111", W_ILL);
        step(7'b0110010, 1'b0); check("illegal_0110010", W_ILL);
        step(7'b0110011, 1'b0); check("r_after_illegal", W_R);

        // Outputs must hold when opcode changes between edges.
        @(negedge clk);
        opcode = 7'b0000011;
        #2;
        check("hold_between_edges", W_R);

        step(7'b0000011, 1'b0); check("load_again", W_LD);
        step(7'b0000011, 1'b1); check("midstream_reset", W_ZERO);
        step(7'b0000011, 1'b0); check("load_after_reset", W_LD);
        step(7'b1100111, 1'b0); check("jalr_after_load", W_JALR);
        step(7'b1100011, 1'b0); check("branch_after_jalr", W_BR);
        step(7'b0100111, 1'b0); check("illegal_0100111", W_ILL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
